// File: rtl/interval_timer.sv
// Run-time programmable interval timer with periodic and one-shot modes,
// start/stop/resume control, a reloadable period and registered outputs.
module interval_timer #(
  parameter int CNT_W         = 29,
  parameter int DEFAULT_TICKS = 500000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear_done,
  output logic             pulse,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  localparam logic [CNT_W-1:0] DEFAULT_P = CNT_W'(DEFAULT_TICKS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic             terminal;
  logic             done_set;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values computed by the combinational process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= DEFAULT_P;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
    end
  end

  // period_q is never 0, so P-1 cannot underflow.
  assign terminal = (count_q >= (period_q - ONE));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    pulse_d  = 1'b0;
    mode_d   = mode_q;
    done_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          count_d = '0;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (start) begin
          count_d = '0;
          mode_d  = mode;
        end else if (terminal) begin
          count_d = '0;
          pulse_d = 1'b1;
          if (mode_q) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end
      HOLD: begin
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
        end
      end
      default: state_d = IDLE;
    endcase

    period_d = period_q;
    if (load_en) period_d = (load_val == '0) ? ONE : load_val;

    // A one-shot terminal outranks a simultaneous clear.
    done_d = done_q;
    if (done_set)        done_d = 1'b1;
    else if (clear_done) done_d = 1'b0;
  end

  always_comb begin
    busy  = (state_q == RUN);
    pulse = pulse_q;
    done  = done_q;
    count = count_q;
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed, table-driven bench for interval_timer with DEFAULT_TICKS = 5,
// plus a hand-written asynchronous reset sequence.
module tb_interval_timer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, stop, mode, load_en, clear_done;
  logic [CNT_W-1:0] load_val;
  logic             pulse, done, busy;
  logic [CNT_W-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       st, sp, md, le, cd;
    logic [7:0] lv;
    logic       p, d, b;
    logic [7:0] c;
  } vec_t;

  vec_t vecs[$];

  interval_timer #(.CNT_W(CNT_W), .DEFAULT_TICKS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .load_en(load_en), .load_val(load_val), .clear_done(clear_done),
    .pulse(pulse), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {pulse, done, busy, count};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got p=%b d=%b b=%b c=%0d, expected p=%b d=%b b=%b c=%0d",
               name, act[10], act[9], act[8], act[7:0],
               exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic void add(input logic st, sp, md, le, input int lv, input logic cd,
                              input logic p, d, b, input int c);
    vec_t v;
    v.st = st; v.sp = sp; v.md = md; v.le = le; v.lv = 8'(lv); v.cd = cd;
    v.p = p; v.d = d; v.b = b; v.c = 8'(c);
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic st, sp, md, le, input logic [7:0] lv, input logic cd);
    start = st; stop = sp; mode = md; load_en = le; load_val = lv; clear_done = cd;
  endtask

  task automatic idle_rows(input int n, input logic d, input int c0, input logic md);
    for (int k = 0; k < n; k++) add(0, 0, md, 0, 0, 0, 0, d, 1, c0 + k);
  endtask

  initial begin
    // Periodic run, P = 5: pulses after E0+5, E0+10, E0+15.
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int r = 0; r < 3; r++) begin
      idle_rows(4, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    end
    idle_rows(3, 0, 1, 0);
    // Stop at count 3 for four cycles, then resume.
    for (int k = 0; k < 4; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // start together with stop in RUN pauses.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle_rows(3, 0, 2, 0);
    // Retrigger at count 4: no pulse, full period follows.
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_rows(4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // Load P = 10, run to 7, then load 4: terminal on the following edge.
    add(0, 0, 0, 1, 10, 0, 0, 0, 1, 1);
    idle_rows(6, 0, 2, 0);
    add(0, 0, 0, 1, 4, 0, 0, 0, 1, 8);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    idle_rows(3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // load_val = 0 means P = 1: pulse stays high.
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 5, 0, 1, 0, 1, 0);
    // One-shot.
    add(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle_rows(4, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Clear on the same edge as a one-shot terminal: set wins.
    add(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle_rows(4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    // New periodic start keeps done; mode change mid-run is ignored.
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k < 5; k++) add(0, 0, 1, 0, 0, 0, 0, 1, 1, k);
    add(0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1, 1);

    reset = 1'b1;
    drive(0, 0, 0, 0, 8'd0, 0);
    #12;
    check("reset_state", 11'b000_00000000);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].sp, vecs[i].md, vecs[i].le, vecs[i].lv, vecs[i].cd);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {vecs[i].p, vecs[i].d, vecs[i].b, vecs[i].c});
    end

    // Async reset mid-cycle with P = 7 and count = 3.
    @(negedge clk);
    drive(1, 0, 0, 1, 8'd7, 0);
    @(posedge clk); #1;
    check("pre_reset_start", {3'b011, 8'd0});
    @(negedge clk);
    drive(0, 0, 0, 0, 8'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_count", {3'b011, 8'd3});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 11'b000_00000000);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_idle%0d", k), 11'b000_00000000);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 8'd0, 0);
    @(posedge clk); #1;
    check("restart", {3'b001, 8'd0});
    @(negedge clk);
    drive(0, 0, 0, 0, 8'd0, 0);
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("restart_cnt%0d", k), {3'b001, 8'(k)});
    end
    @(posedge clk); #1;
    check("default_period_restored", {3'b101, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Parametrised, run-time programmable interval timer. It replaces fixed-period delay counters in the vending-machine datapath (dispense timeout, UART idle timeout, display hold). It supports periodic and one-shot modes, start/stop/resume control and a reloadable period register. Its outputs are a single-cycle tick, a sticky done flag and a visible count.

Parameters:
CNT_W, 29, width of counter, period register and load_val.
DEFAULT_TICKS, 500000000, period loaded at reset, in clk cycles (5 s at 100 MHz); must fit in CNT_W bits and be >= 1.

Ports:
clk  in  1  system clock (100 MHz nominal).
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  level sampled each edge; start/restart/resume request.
stop  in  1  level sampled each edge; pause request.
mode  in  1  0 = periodic, 1 = one-shot; sampled when start is accepted.
load_en  in  1  write load_val into period register.
load_val  in  CNT_W  new period in cycles; 0 is treated as 1.
clear_done  in  1  clears sticky done.
pulse  out  1  one-cycle tick at each terminal count.
done  out  1  sticky; set at one-shot terminal count.
busy  out  1  high while in RUN.
count  out  CNT_W  current cycle count within the period.

Behaviour:
- Reset (asynchronous, any time, including mid-count):
  - state = IDLE; count = 0; pulse = 0; done = 0; busy = 0.
  - Period register P = DEFAULT_TICKS; latched mode = 0.
- State machine: IDLE, RUN, HOLD. All outputs are registered. busy = (state == RUN).
- IDLE:
  - start = 1: go to RUN, count <= 0, latch mode.
  - stop is ignored.
- RUN:
  - Each edge, count <= count + 1.
  - Terminal condition is count >= P-1. At that edge: count <= 0, pulse <= 1.
  - Periodic mode: stay in RUN.
  - One-shot mode: go to IDLE and set done <= 1.
  - pulse is low on every non-terminal edge.
- RUN, stop = 1: go to HOLD; count is frozen; pulse <= 0.
- RUN, start = 1 (without stop): retrigger. count <= 0, mode re-latched, no pulse on that edge, even if count was terminal.
- HOLD:
  - start = 1 (without stop): return to RUN and resume from the frozen count. Mode is re-latched.
  - Otherwise hold.
- Priority when start and stop are asserted on the same edge: stop wins. In IDLE both are ignored.
- Timing: start accepted at edge E0 (count = 0 after E0). The first pulse is high for the cycle following edge E0+P. Periodic pulses then follow every P cycles exactly. Period is exactly P cycles, never P+1.
- P = 1 in periodic mode: pulse is high continuously. count stays 0.
- Period load:
  - load_en = 1: P <= max(load_val, 1) at that edge, in any state.
  - The new P is used for the compare from the next edge.
  - If the running count is already >= new P-1, the terminal fires on the next edge. There is no wrap-around past 2^CNT_W.
- count never exceeds P-1 in steady state. Width arithmetic is CNT_W bits, unsigned.
- done:
  - Set only by a one-shot terminal count; held until clear_done or reset.
  - If set and clear_done occur on the same edge, set wins.
  - Starting a new run does not clear done.
- mode changes while RUN or HOLD have no effect until the next accepted start.

Test Plan:
- DEFAULT_TICKS=5 override; assert reset, release, start=1 for one cycle with mode=0 -> pulse high for one cycle after edges E0+5, E0+10, E0+15; busy=1 throughout; count sequence 0,1,2,3,4,0.
- mode=1, start -> single pulse after edge E0+5; done=1 from that edge; busy=0; state IDLE. Then clear_done=1 -> done=0 next edge. Then clear_done and a new terminal on the same edge -> done stays 1.
- Periodic run; stop at count=3 for 4 cycles -> count frozen at 3, no pulse, busy=0. Then start -> pulse 2 cycles after resume. start and stop together in RUN -> HOLD.
- Running with P=10, count=7; load_en with load_val=4 -> pulse on the next edge, then period 4. load_val=0 -> period 1, pulse continuously high.
- Retrigger: start at count=4 of P=5 -> no pulse, count returns to 0, next pulse 5 cycles later.
- Assert reset asynchronously mid-cycle while RUN with count=3, pulse pending -> pulse, done, busy, count all 0 immediately. P restored to DEFAULT_TICKS; no pulse after release until a new start.
